scroll_scheduler: RTL and testbench
===================================

# scroll_scheduler

Frame-synchronous controller that sequences the horizontal scroll offset feeding the stripe pattern datapath. It sits between the sync generator's `hpos`/`vpos` outputs and the pixel colour logic. It updates the offset exactly once per frame, at a fixed blanking line, so the pattern never tears mid-frame. Run/stop, speed, direction and a single-frame step handshake are driven from the dedicated inputs.

## Interface
- `WIDTH`, 10: offset width; arithmetic is modulo 2^WIDTH.
- `TICK_LINE`, 480: `vpos` value on which the frame update occurs (first blanking line).
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `hpos`  in  10  horizontal position from the sync generator.
- `vpos`  in  10  vertical position from the sync generator.
- `cfg_run`  in  1  1 = advance every frame.
- `cfg_speed`  in  3  step magnitude minus one; per-frame delta is `cfg_speed+1` (1..8).
- `cfg_dir`  in  1  0 = offset increases, 1 = offset decreases.
- `step_req`  in  1  level request for one single-frame advance while stopped.
- `step_ack`  out  1  one-cycle pulse when a requested step is applied.
- `offset`  out  WIDTH  scroll offset added to `pix_x` by the datapath.
- `frame_tick`  out  1  one-cycle pulse on every frame update edge.
- `frame_count`  out  8  free-running frame counter.

## Operation
- Detect condition `det = (vpos == TICK_LINE) && (hpos == 0)`. Sampled every cycle; true for one cycle per frame.
- On the edge where `det` is high, `frame_tick` is registered to 1 for the following cycle. In all other cycles it is 0.
- `frame_count` increments by 1 on every `det` edge in every state, and wraps from 255 to 0.
- Delta `d = cfg_speed + 1`, using live inputs in the `det` cycle. Advance means `offset <= cfg_dir ? offset - d : offset + d`, mod 2^WIDTH.
- FSM states: STOP, RUN, STEP.
  - STOP: offset held.
    - `det && cfg_run` → RUN, no advance on that edge.
    - Else, when `step_req && armed` → STEP and clear `armed`.
    - If both conditions hold in the same cycle, RUN wins and the step is discarded; `armed` is untouched.
  - RUN:
    - On `det` with `cfg_run=1`: advance, stay in RUN.
    - On `det` with `cfg_run=0`: → STOP with no advance.
    - `cfg_run` is ignored between `det` edges.
    - `step_req` is ignored.
  - STEP: on `det`, advance, pulse `step_ack` and go to STOP, regardless of `cfg_run`. A `cfg_run=1` is honoured on the next frame's `det`.
- `armed` is set in any cycle where `step_req` is 0. A new step therefore needs `step_req` to be seen low for at least one cycle after the previous request.
- Reset values: state STOP, `offset` 0, `frame_count` 0, `frame_tick` 0, `step_ack` 0, `armed` 0.
  - Because `armed` resets to 0, a `step_req` held high through reset does not trigger a step.
  - Reset asserted mid-frame or mid-step aborts immediately; no ack is produced.

## Timing
- Latency from `det` cycle to the updated `offset`: 1 cycle. `frame_tick`, `step_ack`, the new `offset` and the new `frame_count` all change on the same edge.
- `offset` is stable for a full frame: it changes only on a `det` edge (or reset).
- From `step_req` rising in STOP to `step_ack`: the STEP transition takes 1 cycle, then the wait for the next `det`, then the 1-cycle update. Worst case is about one frame.
- No combinational path exists from any input to any output.

## Structure
- Shared package `vga_ctrl_pkg` holds:
  - the state enum (STOP/RUN/STEP);
  - `TICK_LINE_DEFAULT` = 480;
  - the frame geometry constants shared with the sync generator.
- Natural sub-module: `frame_tick_detect`, containing the `det` compare, the registered `frame_tick` and `frame_count`. The FSM and offset arithmetic stay in `scroll_scheduler`.

## Test plan
- Reset, then `cfg_run=1`, `cfg_speed=2`, `cfg_dir=0`, over 4 frames → `offset` 0 after the first `det` (entering RUN), then 3, 6, 9. `frame_tick` pulses once per frame; `frame_count` reads 4.
- RUN with `cfg_speed=0`, `cfg_dir=1` from `offset` 0 → next frame `offset`=1023; the frame after that, 1022 (wrap-around).
- STOP with `cfg_speed=7`: raise `step_req` and hold it for 3 frames → exactly one `step_ack` pulse and `offset` +8. Drop `step_req` for 1 cycle and raise it again → second ack, `offset` +16 total.
- STEP pending with `cfg_run=1` at `det` → step applied, ack, state STOP. At the next `det`, RUN is entered without an advance; advances begin on the following frame.
- RUN, deassert `cfg_run` mid-frame and reassert it before `det` → advance still occurs. Deassert across `det` → no advance, state STOP.
- Assert `reset` for 1 cycle mid-frame in RUN with `offset`=300 and `step_req` high → `offset` 0, `frame_count` 0, no ack; no step until `step_req` has gone low and then high again.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared VGA controller definitions.
// Holds the scroll scheduler state encoding, the default frame-update line,
// and the 640x480 frame geometry shared with the sync generator.
package vga_ctrl_pkg;

    // Scroll scheduler states.
    typedef enum logic [1:0] {
        SCHED_STOP = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_STEP = 2'd2
    } sched_state_e;

    // Frame geometry (640x480 @ 60 Hz timing).
    localparam int H_VISIBLE = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;

    // First blanking line: the offset is updated here so it never changes
    // while visible pixels are being drawn.
    localparam int TICK_LINE_DEFAULT = V_VISIBLE;

endpackage

// File: rtl/scroll_scheduler_if.sv
// Signal bundle between the scroll scheduler and its surroundings.
//   hpos/vpos        : beam position from the sync generator
//   cfg_run/speed/dir: scroll control inputs
//   step_req/step_ack: single-frame step handshake
//   offset           : horizontal scroll offset to the pixel datapath
//   frame_tick       : one-cycle pulse per frame update
//   frame_count      : free-running 8-bit frame counter
// master = environment side, slave = scheduler side.
interface scroll_scheduler_if #(
    parameter int WIDTH = 10
);
    logic [9:0]       hpos;
    logic [9:0]       vpos;
    logic             cfg_run;
    logic [2:0]       cfg_speed;
    logic             cfg_dir;
    logic             step_req;
    logic             step_ack;
    logic [WIDTH-1:0] offset;
    logic             frame_tick;
    logic [7:0]       frame_count;

    modport master (
        output hpos, vpos, cfg_run, cfg_speed, cfg_dir, step_req,
        input  step_ack, offset, frame_tick, frame_count
    );

    modport slave (
        input  hpos, vpos, cfg_run, cfg_speed, cfg_dir, step_req,
        output step_ack, offset, frame_tick, frame_count
    );
endinterface

// File: rtl/scroll_scheduler_frame_tick_detect.sv
// Frame update detector.
// Compares the beam position against the update line and produces:
//   det         : combinational, high for the single cycle at (TICK_LINE, 0);
//                 consumed only by registers in the parent
//   frame_tick  : registered copy of det (one-cycle pulse after the det cycle)
//   frame_count : 8-bit counter incremented on every det edge, wraps 255->0
// Ports: clk, reset (sync, active high), hpos, vpos, det, frame_tick, frame_count.
module frame_tick_detect
    import vga_ctrl_pkg::*;
#(
    parameter int TICK_LINE = TICK_LINE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       det,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    logic       frame_tick_q,  frame_tick_d;
    logic [7:0] frame_count_q, frame_count_d;

    always_comb begin
        det           = (vpos == 10'(TICK_LINE)) && (hpos == 10'd0);
        frame_tick_d  = det;
        frame_count_d = frame_count_q;
        if (det) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;

endmodule

// File: rtl/scroll_scheduler.sv
// Frame-synchronous horizontal scroll scheduler.
// Advances the scroll offset at most once per frame, on the update line, so
// the stripe pattern never tears. Supports free running, stop, and a
// single-frame step handshake.
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active-high reset
//   bus   : scroll_scheduler_if.slave (position, controls, step handshake,
//           offset / frame_tick / frame_count outputs). All outputs are
//           registered.
module scroll_scheduler
    import vga_ctrl_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int TICK_LINE = TICK_LINE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    scroll_scheduler_if.slave   bus
);

    logic det;

    frame_tick_detect #(
        .TICK_LINE (TICK_LINE)
    ) u_detect (
        .clk         (clk),
        .reset       (reset),
        .hpos        (bus.hpos),
        .vpos        (bus.vpos),
        .det         (det),
        .frame_tick  (bus.frame_tick),
        .frame_count (bus.frame_count)
    );

    sched_state_e     state_q,    state_d;
    logic [WIDTH-1:0] offset_q,   offset_d;
    logic             step_ack_q, step_ack_d;
    logic             armed_q,    armed_d;

    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] offset_adv;

    // Candidate next offset using the live speed/direction; wraps naturally
    // at 2^WIDTH.
    always_comb begin
        delta      = WIDTH'(bus.cfg_speed) + WIDTH'(1);
        offset_adv = bus.cfg_dir ? (offset_q - delta) : (offset_q + delta);
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        step_ack_d = 1'b0;
        // A low step_req re-arms the handshake so a held request fires once.
        armed_d    = armed_q | ~bus.step_req;

        unique case (state_q)
            SCHED_STOP: begin
                // Entering RUN takes priority; a coincident step request is
                // dropped without consuming the arm.
                if (det && bus.cfg_run) begin
                    state_d = SCHED_RUN;
                end else if (bus.step_req && armed_q) begin
                    state_d = SCHED_STEP;
                    armed_d = 1'b0;
                end
            end
            SCHED_RUN: begin
                if (det) begin
                    if (bus.cfg_run) begin
                        offset_d = offset_adv;
                    end else begin
                        state_d = SCHED_STOP;
                    end
                end
            end
            SCHED_STEP: begin
                if (det) begin
                    offset_d   = offset_adv;
                    step_ack_d = 1'b1;
                    state_d    = SCHED_STOP;
                end
            end
            default: begin
                state_d = SCHED_STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCHED_STOP;
            offset_q   <= '0;
            step_ack_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            step_ack_q <= step_ack_d;
            armed_q    <= armed_d;
        end
    end

    assign bus.offset   = offset_q;
    assign bus.step_ack = step_ack_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
module tb_scroll_scheduler;

    localparam int W    = 10;
    localparam int MASK = (1 << W) - 1;
    localparam int TL   = 480;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    scroll_scheduler_if #(.WIDTH(W)) bus();

    scroll_scheduler #(.WIDTH(W), .TICK_LINE(TL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode flags rather than a state register.
    int m_off, m_cnt, m_tick, m_ack;
    bit running, step_pending, may_step;

    // Observed pulse counters.
    int acks_seen  = 0;
    int ticks_seen = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply the scheduler rules for one clock edge using the inputs present.
    task automatic model_edge();
        bit det;
        int d, adv;
        if (reset) begin
            m_off = 0; m_cnt = 0; m_tick = 0; m_ack = 0;
            running = 0; step_pending = 0; may_step = 0;
            return;
        end
        det    = (int'(bus.vpos) == TL) && (bus.hpos == 10'd0);
        m_tick = det ? 1 : 0;
        m_ack  = 0;
        if (det) m_cnt = (m_cnt + 1) % 256;
        d   = int'(bus.cfg_speed) + 1;
        adv = bus.cfg_dir ? ((m_off - d) & MASK) : ((m_off + d) & MASK);
        if (step_pending) begin
            if (det) begin
                m_off = adv; m_ack = 1; step_pending = 0;
            end
        end else if (running) begin
            if (det) begin
                if (bus.cfg_run) m_off = adv;
                else running = 0;
            end
        end else begin
            if (det && bus.cfg_run) running = 1;
            else if (bus.step_req && may_step) begin
                step_pending = 1; may_step = 0;
            end
        end
        if (!bus.step_req) may_step = 1;
    endtask

    // One clock: drive position, take the edge, compare all outputs 1 ns later.
    task automatic drive_cycle(input int h, input int v);
        bus.hpos = 10'(h);
        bus.vpos = 10'(v);
        @(posedge clk);
        model_edge();
        #1;
        if (bus.step_ack)   acks_seen++;
        if (bus.frame_tick) ticks_seen++;
        check_val("offset",      int'(bus.offset),      m_off);
        check_val("frame_count", int'(bus.frame_count), m_cnt);
        check_val("frame_tick",  int'(bus.frame_tick),  m_tick);
        check_val("step_ack",    int'(bus.step_ack),    m_ack);
    endtask

    // A non-update position, including near misses of the update point.
    task automatic idle_cycle();
        int h, v;
        case ($urandom_range(0, 3))
            0: begin h = 1;   v = TL;     end
            1: begin h = 0;   v = TL - 1; end
            2: begin h = 0;   v = TL + 1; end
            default: begin h = $urandom_range(0, 799); v = $urandom_range(0, 524); end
        endcase
        if (h == 0 && v == TL) h = 5;
        drive_cycle(h, v);
    endtask

    task automatic run_frame(input int gap);
        repeat (gap) idle_cycle();
        drive_cycle(0, TL);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) drive_cycle(3, 3);
        reset = 1'b0;
    endtask

    int base, a0, t0;

    initial begin
        reset         = 1'b1;
        bus.hpos      = '0;
        bus.vpos      = '0;
        bus.cfg_run   = 1'b0;
        bus.cfg_speed = 3'd0;
        bus.cfg_dir   = 1'b0;
        bus.step_req  = 1'b0;

        // Reset state and basic run at speed 3.
        do_reset(2);
        check_val("rst_offset", int'(bus.offset), 0);
        check_val("rst_count",  int'(bus.frame_count), 0);
        bus.cfg_run = 1'b1; bus.cfg_speed = 3'd2; bus.cfg_dir = 1'b0;
        t0 = ticks_seen;
        for (int f = 0; f < 4; f++) begin
            run_frame(20);
            check_val("run_offset", int'(bus.offset), f * 3);
        end
        repeat (3) idle_cycle();
        check_val("run_count", int'(bus.frame_count), 4);
        check_val("run_ticks", ticks_seen - t0, 4);

        // Decrement across zero.
        do_reset(1);
        bus.cfg_run = 1'b1; bus.cfg_speed = 3'd0; bus.cfg_dir = 1'b1;
        run_frame(6);
        check_val("dec_enter", int'(bus.offset), 0);
        run_frame(6);
        check_val("dec_wrap1", int'(bus.offset), 1023);
        run_frame(6);
        check_val("dec_wrap2", int'(bus.offset), 1022);

        // Stop, then a held step request gives exactly one step.
        bus.cfg_run = 1'b0;
        run_frame(4);
        base = 1022;
        bus.cfg_speed = 3'd7; bus.cfg_dir = 1'b0;
        a0 = acks_seen;
        bus.step_req = 1'b1;
        repeat (3) run_frame(8);
        check_val("hold_acks",   acks_seen - a0, 1);
        check_val("hold_offset", int'(bus.offset), (base + 8) & MASK);
        bus.step_req = 1'b0;
        idle_cycle();
        bus.step_req = 1'b1;
        run_frame(8);
        check_val("rearm_acks",   acks_seen - a0, 2);
        check_val("rearm_offset", int'(bus.offset), (base + 16) & MASK);
        bus.step_req = 1'b0;
        idle_cycle();

        // Step pending while cfg_run rises: step first, RUN entered next frame.
        base = int'(bus.offset);
        a0 = acks_seen;
        bus.step_req = 1'b1;
        idle_cycle();
        bus.step_req = 1'b0;
        bus.cfg_run  = 1'b1;
        run_frame(5);
        check_val("step_run_ack", acks_seen - a0, 1);
        check_val("step_run_off", int'(bus.offset), (base + 8) & MASK);
        run_frame(5);
        check_val("enter_run_off", int'(bus.offset), (base + 8) & MASK);
        run_frame(5);
        check_val("first_adv_off", int'(bus.offset), (base + 16) & MASK);

        // cfg_run glitch between updates is ignored; low across det stops.
        base = int'(bus.offset);
        idle_cycle();
        bus.cfg_run = 1'b0;
        repeat (3) idle_cycle();
        bus.cfg_run = 1'b1;
        run_frame(2);
        check_val("glitch_adv", int'(bus.offset), (base + 8) & MASK);
        bus.cfg_run = 1'b0;
        run_frame(3);
        check_val("stop_hold", int'(bus.offset), (base + 8) & MASK);
        run_frame(3);
        check_val("stop_hold2", int'(bus.offset), (base + 8) & MASK);

        // Reset mid-frame at offset 300 with step_req high.
        bus.cfg_run = 1'b0;
        do_reset(1);
        bus.cfg_run = 1'b1; bus.cfg_speed = 3'd4; bus.cfg_dir = 1'b0;
        repeat (61) run_frame(4);
        check_val("pre_rst_off", int'(bus.offset), 300);
        a0 = acks_seen;
        bus.step_req = 1'b1;
        bus.cfg_run  = 1'b0;
        repeat (3) idle_cycle();
        do_reset(1);
        check_val("mid_rst_off", int'(bus.offset), 0);
        check_val("mid_rst_cnt", int'(bus.frame_count), 0);
        repeat (2) run_frame(6);
        check_val("no_step_acks", acks_seen - a0, 0);
        check_val("no_step_off",  int'(bus.offset), 0);
        bus.step_req = 1'b0;
        idle_cycle();
        bus.step_req = 1'b1;
        run_frame(6);
        check_val("post_rst_ack", acks_seen - a0, 1);
        check_val("post_rst_off", int'(bus.offset), 5);
        bus.step_req = 1'b0;

        // Randomised traffic against the model.
        for (int f = 0; f < 300; f++) begin
            int gap;
            bus.cfg_run   = ($urandom_range(0, 2) != 0);
            bus.cfg_speed = 3'($urandom_range(0, 7));
            bus.cfg_dir   = 1'($urandom_range(0, 1));
            gap = $urandom_range(1, 12);
            for (int c = 0; c < gap; c++) begin
                if ($urandom_range(0, 3) == 0) bus.step_req = ~bus.step_req;
                if ($urandom_range(0, 99) < 2) do_reset(1);
                else idle_cycle();
            end
            if ($urandom_range(0, 3) == 0) bus.cfg_run = ~bus.cfg_run;
            drive_cycle(0, TL);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
